// File: rtl/riscv_fetch_ctrl.sv
// Instruction fetch controller: issues one word-aligned fetch at a time to
// instruction memory and stages the returned instruction in a one-entry
// output buffer. Redirects retarget the PC, flush the buffer and kill the
// response of any request already accepted.
module riscv_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst,
    // Instruction-memory request channel
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    // Instruction-memory response channel
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    // Control flow
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    // Output buffer towards decode
    input  logic        f_ready,
    output logic        f_valid,
    output logic [31:0] f_inst,
    output logic [31:0] f_pc,
    output logic        fetch_misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        kill_q, kill_d;
    logic        f_valid_q, f_valid_d;
    logic [31:0] f_inst_q, f_inst_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        misaligned_q, misaligned_d;

    logic drain;
    logic req_valid;
    logic accept;
    logic load;

    // Handshake terms shared by the FSM and the output buffer
    always_comb begin
        drain     = f_valid_q && f_ready && !stall;
        // A request only goes out when the buffer will have room for its answer.
        req_valid = (state_q == StReq) && (!f_valid_q || drain);
        accept    = req_valid && imem_req_ready;
        // Responses outside WAIT are protocol violations and never reach the buffer.
        load      = (state_q == StWait) && imem_resp_valid && !kill_q && !redirect_valid;
    end

    // FSM next state, fetch PC and kill tracking
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        kill_d        = kill_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (accept) begin
                    state_d       = StWait;
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                    // The request just accepted belongs to the old stream.
                    kill_d        = redirect_valid;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    state_d = StReq;
                    kill_d  = 1'b0;
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Redirect overrides any sequential advance.
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    // Output buffer next state and sticky misalignment flag
    always_comb begin
        f_valid_d    = f_valid_q;
        f_inst_d     = f_inst_q;
        f_pc_d       = f_pc_q;
        misaligned_d = misaligned_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));

        if (redirect_valid) begin
            f_valid_d = 1'b0;
        end else if (load) begin
            // A load in the same cycle as a drain simply replaces the entry.
            f_valid_d = 1'b1;
            f_inst_d  = imem_resp_data;
            f_pc_d    = inflight_pc_q;
        end else if (drain) begin
            f_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            kill_q        <= 1'b0;
            f_valid_q     <= 1'b0;
            f_inst_q      <= NOP;
            f_pc_q        <= 32'h0000_0000;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            f_valid_q     <= f_valid_d;
            f_inst_q      <= f_inst_d;
            f_pc_q        <= f_pc_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign imem_req_valid   = req_valid;
    assign imem_req_addr    = pc_q;
    assign f_valid          = f_valid_q;
    assign f_inst           = f_inst_q;
    assign f_pc             = f_pc_q;
    assign fetch_misaligned = misaligned_q;

endmodule
